// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan decoder: active-low segment
// patterns ({g,f,e,d,c,b,a}), the scan FSM states and the default settle length.
package sseg_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational pattern-to-nibble decoder; unknown patterns give 4'hF with o_valid low.
// Letters A,b,C,d,E,F decode as valid only when SSEG_DEC_HEX_EN is defined.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_value,
  output logic       o_valid
);

  always_comb begin
    o_value = 4'hF;
    o_valid = 1'b0;
    case (i_pattern)
      SEG_0: {o_valid, o_value} = {1'b1, 4'h0};
      SEG_1: {o_valid, o_value} = {1'b1, 4'h1};
      SEG_2: {o_valid, o_value} = {1'b1, 4'h2};
      SEG_3: {o_valid, o_value} = {1'b1, 4'h3};
      SEG_4: {o_valid, o_value} = {1'b1, 4'h4};
      SEG_5: {o_valid, o_value} = {1'b1, 4'h5};
      SEG_6: {o_valid, o_value} = {1'b1, 4'h6};
      SEG_7: {o_valid, o_value} = {1'b1, 4'h7};
      SEG_8: {o_valid, o_value} = {1'b1, 4'h8};
      SEG_9: {o_valid, o_value} = {1'b1, 4'h9};
`ifdef SSEG_DEC_HEX_EN
      SEG_A: {o_valid, o_value} = {1'b1, 4'hA};
      SEG_B: {o_valid, o_value} = {1'b1, 4'hB};
      SEG_C: {o_valid, o_value} = {1'b1, 4'hC};
      SEG_D: {o_valid, o_value} = {1'b1, 4'hD};
      SEG_E: {o_valid, o_value} = {1'b1, 4'hE};
      SEG_F: {o_valid, o_value} = {1'b1, 4'hF};
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Rebuilds four digits from a multiplexed seven-segment scan; a digit is captured after STABLE_CYCLES
// identical samples, the frame publishes one cycle after the fourth capture; no backpressure. Option: SSEG_DEC_HEX_EN.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        R,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic [3:0]  dig_err,
  output logic        an_err
);

  // Counter holds (stable samples - 1); capture fires on the sample that completes the run.
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 2);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [3:0]  r_an_prev;
  logic [6:0]  r_sseg_prev;
  logic [3:0]  r_mask;
  logic [15:0] r_shadow;
  logic [3:0]  r_shadow_err;
  logic [15:0] r_digits;
  logic [3:0]  r_dig_err;
  logic        r_frame_valid;
  logic        r_an_err;

  logic [3:0]  w_an_lo;
  logic        w_blank;
  logic        w_multi;
  logic        w_changed;
  logic        w_capture;
  logic [3:0]  w_cap_bits;
  logic [3:0]  w_mask_base;
  logic        w_frame_done;
  logic [3:0]  w_dec_val;
  logic        w_dec_vld;

  sseg_pattern_decode u_decode (
    .i_pattern (sseg),
    .o_value   (w_dec_val),
    .o_valid   (w_dec_vld)
  );

  assign w_an_lo      = ~an;
  assign w_blank      = (an == 4'hF);
  assign w_multi      = ((w_an_lo & (w_an_lo - 4'd1)) != 4'd0);
  assign w_changed    = (an != r_an_prev) || (sseg != r_sseg_prev);
  assign w_cap_bits   = w_capture ? w_an_lo : 4'h0;
  assign w_frame_done = (r_mask == 4'hF);
  assign w_mask_base  = w_frame_done ? 4'h0 : r_mask;

  // Blank and multi-anode inputs pre-empt every state; otherwise exactly one anode is low.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (w_blank || w_multi) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = 8'd0;
        end
        SETTLE: begin
          if (w_changed) begin
            w_cnt_nxt = 8'd0;
          end else if (r_cnt == CNT_LAST) begin
            w_capture   = 1'b1;
            w_state_nxt = HELD;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        HELD: begin
          if (w_changed) begin
            w_state_nxt = SETTLE;
            w_cnt_nxt   = 8'd0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      r_state       <= IDLE;
      r_cnt         <= 8'd0;
      r_an_prev     <= 4'hF;
      r_sseg_prev   <= 7'h7F;
      r_mask        <= 4'h0;
      r_shadow      <= 16'h0;
      r_shadow_err  <= 4'h0;
      r_digits      <= 16'h0;
      r_dig_err     <= 4'h0;
      r_frame_valid <= 1'b0;
      r_an_err      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_an_prev     <= an;
      r_sseg_prev   <= sseg;
      r_an_err      <= w_multi;
      r_frame_valid <= w_frame_done;
      r_mask        <= w_mask_base | w_cap_bits;
      if (w_frame_done) begin
        r_digits  <= r_shadow;
        r_dig_err <= r_shadow_err;
      end
      for (int k = 0; k < 4; k++) begin
        if (w_cap_bits[k]) begin
          r_shadow[k*4 +: 4] <= w_dec_val;
          r_shadow_err[k]    <= ~w_dec_vld;
        end
      end
    end
  end

  assign digits      = r_digits;
  assign dig_err     = r_dig_err;
  assign frame_valid = r_frame_valid;
  assign an_err      = r_an_err;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Scoreboard bench for sseg_scan_decoder: a run-length reference model predicts frames and an_err,
// a negedge monitor compares; directed scenarios first, then randomized scans.
module tb_sseg_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        R;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic [15:0] digits;
  logic        frame_valid;
  logic [3:0]  dig_err;
  logic        an_err;

  sseg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .R           (R),
    .an          (an),
    .sseg        (sseg),
    .digits      (digits),
    .frame_valid (frame_valid),
    .dig_err     (dig_err),
    .an_err      (an_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  err;
  } frame_t;

  // Displayed glyphs 0-9 then A,b,C,d,E,F, active-low {g,f,e,d,c,b,a}.
  logic [6:0] pat_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     nframes  = 0;
  int     n_anerr  = 0;
  logic [15:0] last_dig = 16'h0;
  logic [3:0]  last_err = 4'h0;

  // Model state, updated on each rising edge.
  int          run = 0;
  logic [3:0]  prev_an = 4'hF;
  logic [6:0]  prev_sseg = 7'h7F;
  logic [3:0]  m_mask = 4'h0;
  logic [3:0]  m_val [4];
  logic        m_err [4];
  bit          m_pend = 1'b0;
  bit          m_fv = 1'b0;
  bit          m_an_err = 1'b0;
  bit          m_rst_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] v, output logic e);
    int n;
`ifdef SSEG_DEC_HEX_EN
    n = 16;
`else
    n = 10;
`endif
    v = 4'hF;
    e = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (pat_tbl[i] == p) begin
        v = 4'(i);
        e = 1'b0;
      end
    end
  endfunction

  // Reference model: a digit is captured when a single-anode (an,sseg) pair has been
  // sampled S times in a row; a full set of four publishes on the following edge.
  initial begin
    int         zeros;
    int         k;
    logic [3:0] v;
    logic       e;
    frame_t     f;
    for (int i = 0; i < 4; i++) begin m_val[i] = 4'h0; m_err[i] = 1'b0; end
    forever begin
      @(posedge clk);
      m_rst_last = R;
      if (R) begin
        run = 0; m_mask = 4'h0; m_pend = 1'b0; m_fv = 1'b0; m_an_err = 1'b0;
        for (int i = 0; i < 4; i++) begin m_val[i] = 4'h0; m_err[i] = 1'b0; end
      end else begin
        m_fv = m_pend;
        if (m_pend) begin
          f.dig = {m_val[3], m_val[2], m_val[1], m_val[0]};
          f.err = {m_err[3], m_err[2], m_err[1], m_err[0]};
          exp_q.push_back(f);
          m_mask = 4'h0;
        end
        zeros = 0;
        k = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; k = i; end
        m_an_err = (zeros > 1);
        if (zeros == 1) begin
          if (run > 0 && an == prev_an && sseg == prev_sseg) run++;
          else run = 1;
          if (run == S) begin
            ref_decode(sseg, v, e);
            m_val[k] = v; m_err[k] = e; m_mask[k] = 1'b1;
          end
        end else begin
          run = 0;
        end
        m_pend = (m_mask == 4'hF);
      end
      prev_an = an;
      prev_sseg = sseg;
    end
  end

  // Monitor: compares on the falling edge, popping the scoreboard on each frame_valid.
  initial begin
    frame_t     f;
    logic [15:0] hold_dig = 16'h0;
    logic [3:0]  hold_err = 4'h0;
    forever begin
      @(negedge clk);
      if (m_rst_last) begin
        chk("rst_digits", digits, 16'h0);
        chk("rst_dig_err", dig_err, 4'h0);
        chk("rst_frame_valid", frame_valid, 1'b0);
        chk("rst_an_err", an_err, 1'b0);
        hold_dig = 16'h0;
        hold_err = 4'h0;
      end else begin
        chk("an_err", an_err, m_an_err);
        chk("frame_valid", frame_valid, m_fv);
        if (an_err) n_anerr++;
        if (frame_valid) begin
          if (exp_q.size() == 0) begin
            chk("frame_expected", 0, 1);
          end else begin
            f = exp_q.pop_front();
            chk("frame_digits", digits, f.dig);
            chk("frame_dig_err", dig_err, f.err);
            hold_dig = f.dig;
            hold_err = f.err;
          end
          nframes++;
          last_dig = digits;
          last_err = dig_err;
        end else begin
          chk("digits_hold", digits, hold_dig);
          chk("dig_err_hold", dig_err, hold_err);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    sseg = s;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int         f0;
    int         e0;
    int         r;
    int         k;
    logic [3:0] a;
    logic [6:0] p;

    R = 1'b1;
    drive(4'hF, 7'h7F, 2);
    R = 1'b0;
    drive(4'hF, 7'h7F, 2);

    // Normal scan: expect 0,0,9,1.
    f0 = nframes;
    drive(4'hE, 7'h79, 16); drive(4'hD, 7'h10, 16);
    drive(4'hB, 7'h40, 16); drive(4'h7, 7'h40, 16);
    drive(4'hF, 7'h7F, 2);
    chk("scan_frames", nframes - f0, 1);
    chk("scan_digits", last_dig, 16'h0091);
    chk("scan_dig_err", last_err, 4'h0);

    // Glitch on the last digit: three samples of each pattern must not capture.
    f0 = nframes;
    drive(4'hD, 7'h79, 6); drive(4'hB, 7'h40, 6); drive(4'h7, 7'h40, 6);
    drive(4'hE, 7'h79, 3); drive(4'hE, 7'h24, 3);
    drive(4'hF, 7'h7F, 3);
    chk("glitch_no_frame", nframes - f0, 0);
    drive(4'hE, 7'h24, 4);
    drive(4'hF, 7'h7F, 3);
    chk("glitch_frames", nframes - f0, 1);
    chk("glitch_digits", last_dig, 16'h0012);

    // Undecodable pattern on digit 0.
    f0 = nframes;
    drive(4'hE, 7'h7F, 6); drive(4'hD, 7'h10, 6);
    drive(4'hB, 7'h40, 6); drive(4'h7, 7'h79, 6);
    drive(4'hF, 7'h7F, 3);
    chk("invalid_frames", nframes - f0, 1);
    chk("invalid_digits", last_dig, 16'h109F);
    chk("invalid_dig_err", last_err, 4'b0001);

    // Two anodes low for one cycle.
    e0 = n_anerr;
    f0 = nframes;
    drive(4'hC, 7'h40, 1);
    drive(4'hF, 7'h7F, 3);
    chk("multi_an_err_pulses", n_anerr - e0, 1);
    chk("multi_no_frame", nframes - f0, 0);

    // Reset after three captures discards them.
    drive(4'hE, 7'h78, 6); drive(4'hD, 7'h78, 6); drive(4'hB, 7'h78, 6);
    R = 1'b1;
    drive(4'h7, 7'h78, 2);
    R = 1'b0;
    drive(4'hF, 7'h7F, 1);
    f0 = nframes;
    drive(4'hD, 7'h19, 6); drive(4'hB, 7'h12, 6); drive(4'h7, 7'h02, 6);
    drive(4'hF, 7'h7F, 3);
    chk("reset_partial_no_frame", nframes - f0, 0);
    drive(4'hE, 7'h30, 6);
    drive(4'hF, 7'h7F, 3);
    chk("reset_frames", nframes - f0, 1);
    chk("reset_digits", last_dig, 16'h6543);

    // Letter A on digit 0.
    drive(4'hE, 7'h08, 6); drive(4'hD, 7'h40, 6);
    drive(4'hB, 7'h40, 6); drive(4'h7, 7'h40, 6);
    drive(4'hF, 7'h7F, 3);
`ifdef SSEG_DEC_HEX_EN
    chk("hex_digits", last_dig, 16'h000A);
    chk("hex_dig_err", last_err, 4'h0);
`else
    chk("hex_digits", last_dig, 16'h000F);
    chk("hex_dig_err", last_err, 4'h1);
`endif

    // Randomized scans around the stability threshold.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        R = 1'b1;
        drive(an, sseg, $urandom_range(1, 2));
        R = 1'b0;
      end else if (r < 10) begin
        drive(4'hF, 7'h7F, $urandom_range(1, 3));
      end else if (r < 16) begin
        do a = 4'($urandom_range(0, 15)); while ($countones(~a) < 2);
        drive(a, pat_tbl[$urandom_range(0, 15)], $urandom_range(1, 2));
      end else begin
        k = $urandom_range(0, 3);
        a = 4'hF;
        a[k] = 1'b0;
        if ($urandom_range(0, 9) < 8) p = pat_tbl[$urandom_range(0, 15)];
        else p = 7'($urandom);
        drive(a, p, $urandom_range(1, 8));
      end
    end
    R = 1'b0;
    drive(4'hF, 7'h7F, 4);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
